// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues word fetches under a credit limit and
// buffers returned words in order. Optional macro: FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_OUTST  = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_misalign
);
    // state | meaning
    // FETCH | issuing requests under the credit rule
    // FLUSH | draining responses issued before a redirect; they are dropped
    // TRAP  | misaligned redirect seen; idle until an aligned redirect
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] OUTST_C = CW'(MAX_OUTST);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_FETCH, S_FLUSH, S_TRAP} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_FLUSH} state_t;
`endif

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] stale;
    logic          run;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];

    logic [CW-1:0] fifo_count;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] stale_dec;
    logic          req_hs;
    logic          rsp_live;
    logic          pop;
    logic [31:0]   target_aligned;

    assign fifo_count     = CW'(wr_ptr - rd_ptr);
    assign imem_addr      = pc;
    assign imem_req_valid = run && (state == S_FETCH) && !redirect_valid &&
                            ((outstanding + fifo_count) < DEPTH_C) &&
                            (outstanding < OUTST_C);
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign rsp_live       = imem_rsp_valid && (state == S_FETCH) && !redirect_valid;
    assign instr_valid    = (wr_ptr != rd_ptr);
    assign pop            = instr_valid && instr_ready;
    assign instruction    = fifo_data[rd_ptr[AW-1:0]];
    assign instr_pc       = fifo_pc[rd_ptr[AW-1:0]];
    assign target_aligned = redirect_target & ~32'h3;
    assign stale_dec      = stale - CW'(imem_rsp_valid);

    // Every request still in flight after this cycle, live or stale; at most one
    // of stale/outstanding is non-zero, so a response retires from whichever is.
    assign inflight_next  = stale + outstanding + CW'(req_hs) - CW'(imem_rsp_valid);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;
    logic redirect_mis;
    assign redirect_mis   = |redirect_target[1:0];
    assign fetch_misalign = misalign_q;
`else
    assign fetch_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
            run         <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            run <= 1'b1;
            if (redirect_valid) begin
                pc          <= target_aligned;
                rsp_pc      <= target_aligned;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                outstanding <= '0;
                stale       <= inflight_next;
`ifdef FETCH_MISALIGN_TRAP_EN
                misalign_q  <= redirect_mis;
                if (inflight_next != '0)
                    state <= S_FLUSH;
                else
                    state <= redirect_mis ? S_TRAP : S_FETCH;
`else
                state <= (inflight_next != '0) ? S_FLUSH : S_FETCH;
`endif
            end else begin
                if (req_hs)
                    pc <= pc + 32'd4;
                // rsp_pc shadows the address of the oldest live request
                if (rsp_live) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                outstanding <= outstanding + CW'(req_hs) - CW'(rsp_live);
                if (state == S_FLUSH) begin
                    stale <= stale_dec;
                    if (stale_dec == '0) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        state <= misalign_q ? S_TRAP : S_FETCH;
`else
                        state <= S_FETCH;
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_live) begin
            fifo_data[wr_ptr[AW-1:0]] <= imem_rsp_data;
            fifo_pc[wr_ptr[AW-1:0]]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model, scoreboard of expected
// {instruction, pc}, table of redirect vectors plus hand-written corner cases.
module tb_instr_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_misalign;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4), .MAX_OUTST(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fetch_misalign(fetch_misalign)
    );

    typedef struct { logic [31:0] addr; int due; } mem_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } exp_t;
    typedef struct { logic [31:0] target; int lat; bit rnd; logic [31:0] first_pc; } vec_t;

    mem_t        memq[$];
    exp_t        expq[$];
    vec_t        vecs[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc, lat, req_count, pop_count, tb_out, tb_stale, first_valid_cyc;
    logic [31:0] model_pc;
    logic [31:0] first_pc_after;
    bit          got_first, tb_trap, rand_ready;

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(string name, logic act, logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkn(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mem_drive();
        mem_t m;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            m = memq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = m.addr ^ KEY;
        end
    endtask

    // Called just after a falling edge with this cycle's inputs already set.
    task automatic cycle();
        exp_t e;
        mem_t m;
        #1;
        if (instr_valid && first_valid_cyc < 0)
            first_valid_cyc = cyc;
        if (instr_valid && instr_ready) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_instr: got pc %h with nothing expected", instr_pc);
            end else begin
                e = expq.pop_front();
                check32("instr_pc", instr_pc, e.pc);
                check32("instruction", instruction, e.data);
                if (!got_first) begin
                    first_pc_after = instr_pc;
                    got_first = 1'b1;
                end
                pop_count++;
            end
        end
        if (redirect_valid)
            check1("no_req_on_redirect", imem_req_valid, 1'b0);
        else if (tb_stale > 0 || tb_trap)
            check1("no_req_in_flush", imem_req_valid, 1'b0);
        if (imem_req_valid && imem_req_ready) begin
            check32("imem_addr", imem_addr, model_pc);
            m.addr = imem_addr;
            m.due  = cyc + lat;
            memq.push_back(m);
            if (!redirect_valid) begin
                e.data = model_pc ^ KEY;
                e.pc   = model_pc;
                expq.push_back(e);
            end
            model_pc += 32'd4;
            req_count++;
            tb_out++;
        end
        if (imem_rsp_valid) begin
            if (tb_stale > 0) tb_stale--;
            else tb_out--;
        end
        if (redirect_valid) begin
            tb_stale += tb_out;
            tb_out    = 0;
            expq.delete();
            model_pc  = redirect_target & ~32'h3;
            got_first = 1'b0;
            pop_count = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
            tb_trap   = (redirect_target[1:0] != 2'b00);
`endif
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check1("rst_req_valid", imem_req_valid, 1'b0);
        check1("rst_instr_valid", instr_valid, 1'b0);
        memq.delete();
        expq.delete();
        tb_out = 0; tb_stale = 0; tb_trap = 1'b0;
        model_pc = 32'h0; cyc = 0; req_count = 0; pop_count = 0;
        first_valid_cyc = -1; got_first = 1'b0;
        rst = 1'b0;
        #1;
        check1("post_rst_req_valid", imem_req_valid, 1'b0);
        check1("post_rst_instr_valid", instr_valid, 1'b0);
        check32("post_rst_addr", imem_addr, 32'h0);
        check1("post_rst_misalign", fetch_misalign, 1'b0);
    endtask

    task automatic run_until_pops(int n, int budget, string name);
        int k;
        k = 0;
        while (pop_count < n && k < budget) begin
            if (rand_ready) instr_ready = ($urandom_range(1, 0) != 0);
            cycle();
            k++;
        end
        tests++;
        if (pop_count < n) begin
            fails++;
            $display("FAIL %s: timeout with %0d of %0d instructions", name, pop_count, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        vec_t v;
        rst = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        lat = 1;
        rand_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;

        vecs.push_back('{32'hFFFF_FFF8, 1, 1'b0, 32'hFFFF_FFF8});
        vecs.push_back('{32'h0000_1000, 2, 1'b1, 32'h0000_1000});
        vecs.push_back('{32'h0000_0080, 3, 1'b1, 32'h0000_0080});
        vecs.push_back('{32'h0000_0300, 1, 1'b1, 32'h0000_0300});
`ifndef FETCH_MISALIGN_TRAP_EN
        vecs.push_back('{32'h0000_0102, 2, 1'b0, 32'h0000_0100});
`endif

        // Free-running fetch from reset, 1-cycle memory
        do_reset();
        run_until_pops(4, 30, "basic");
        checkn("first_valid_cycle", first_valid_cyc, 3);

        // Back-pressure: credits limit requests to the buffer depth
        do_reset();
        instr_ready = 1'b0;
        repeat (20) cycle();
        checkn("stall_req_count", req_count, 4);
        check1("stall_req_valid", imem_req_valid, 1'b0);
        check1("stall_instr_valid", instr_valid, 1'b1);
        check32("stall_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        run_until_pops(5, 30, "stall_release");

        // Redirect with two requests in flight, 3-cycle memory
        do_reset();
        lat = 3;
        k = 0;
        while (tb_out < 2 && k < 20) begin cycle(); k++; end
        checkn("two_outstanding", tb_out, 2);
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        cycle();
        run_until_pops(2, 40, "redirect_flush");
        check32("redirect_first_pc", first_pc_after, 32'h100);

        // Redirect, response and instr handshake in the same cycle
        do_reset();
        lat = 1;
        k = 0;
        while (!(instr_valid && imem_rsp_valid) && k < 20) begin cycle(); k++; end
        check1("same_cycle_setup", instr_valid && imem_rsp_valid, 1'b1);
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        cycle();
        check1("fifo_empty_after_redirect", instr_valid, 1'b0);
        run_until_pops(3, 30, "same_cycle_redirect");
        check32("same_cycle_first_pc", first_pc_after, 32'h40);

        // Table of redirects applied on a running stream
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            lat = v.lat;
            rand_ready = v.rnd;
            repeat (6) begin
                if (rand_ready) instr_ready = ($urandom_range(1, 0) != 0);
                cycle();
            end
            redirect_valid = 1'b1;
            redirect_target = v.target;
            cycle();
            run_until_pops(4, 200, "vector");
            check32("vector_first_pc", first_pc_after, v.first_pc);
        end
        rand_ready = 1'b0;
        instr_ready = 1'b1;

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect traps; an aligned one recovers
        lat = 2;
        redirect_valid = 1'b1;
        redirect_target = 32'h102;
        cycle();
        repeat (10) cycle();
        check1("misalign_set", fetch_misalign, 1'b1);
        k = req_count;
        repeat (5) cycle();
        checkn("trap_no_req", req_count, k);
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        cycle();
        check1("misalign_clear", fetch_misalign, 1'b0);
        run_until_pops(2, 40, "trap_recover");
        check32("trap_recover_pc", first_pc_after, 32'h200);
`else
        check1("misalign_tied_low", fetch_misalign, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
